lut_neuron_array: RTL and testbench

LUT_NEURON_ARRAY -- requirements
Module: lut_neuron_array

---
 rtl/lut_neuron_array_if.sv | 31 +++
 rtl/lut_neuron_array.sv | 115 +++++++++++
 tb/tb_lut_neuron_array.sv | 361 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut_neuron_array_if.sv
// Stream and configuration signals of the LUT neuron array.
// The master side drives vectors and table writes; the slave side is the array.
interface lut_neuron_array_if #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 2,
    parameter int NIDX_BITS = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
);
    logic [N_NEURONS*IN_BITS-1:0]  in_data;
    logic                          in_valid;
    logic                          in_ready;
    logic [N_NEURONS*OUT_BITS-1:0] out_data;
    logic                          out_valid;
    logic                          out_ready;
    logic                          cfg_we;
    logic [NIDX_BITS-1:0]          cfg_neuron;
    logic [IN_BITS-1:0]            cfg_addr;
    logic [OUT_BITS-1:0]           cfg_data;
    logic                          cfg_ready;
    logic                          init_done;

    modport master (
        output in_data, in_valid, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
        input  in_ready, out_data, out_valid, cfg_ready, init_done
    );

    modport slave (
        input  in_data, in_valid, out_ready, cfg_we, cfg_neuron, cfg_addr, cfg_data,
        output in_ready, out_data, out_valid, cfg_ready, init_done
    );
endinterface

// File: rtl/lut_neuron_array.sv
// Array of independent LUT neurons behind a two-stage valid/ready pipeline.
// Tables are cleared after reset by a sweep before lookups or writes are accepted.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_INIT | sweep clr_cnt over every entry, writing 0 to all tables
//   ST_RUN  | lookups accepted, cfg writes accepted, init_done high
module lut_neuron_array #(
    parameter int N_NEURONS = 4,
    parameter int IN_BITS   = 8,
    parameter int OUT_BITS  = 2
) (
    input logic               clk,
    input logic               rst,
    lut_neuron_array_if.slave bus
);
    localparam int NIDX_BITS = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam int DEPTH     = 2 ** IN_BITS;

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_e;

    state_e                        state_q, state_d;
    logic [IN_BITS-1:0]            clr_cnt_q, clr_cnt_d;
    logic                          clr_we;
    logic                          run;
    logic                          cfg_wr;
    logic                          adv;
    logic                          in_ready;

    logic                          s1_valid_q;
    logic [N_NEURONS*IN_BITS-1:0]  s1_addr_q;
    logic                          out_valid_q;
    logic [N_NEURONS*OUT_BITS-1:0] out_data_q;
    logic [N_NEURONS*OUT_BITS-1:0] rd_data;

    logic [OUT_BITS-1:0]           lut_q [N_NEURONS][DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        run       = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                clr_we    = 1'b1;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == '1) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                run = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign adv      = !out_valid_q || bus.out_ready;
    assign in_ready = run && adv;
    assign cfg_wr   = run && bus.cfg_we;

    // Table writes ignore the pipeline stall; an unmatched neuron index writes nothing.
    always_ff @(posedge clk) begin
        for (int k = 0; k < N_NEURONS; k++) begin
            if (clr_we) begin
                lut_q[k][clr_cnt_q] <= '0;
            end else if (cfg_wr && (bus.cfg_neuron == NIDX_BITS'(k))) begin
                lut_q[k][bus.cfg_addr] <= bus.cfg_data;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < N_NEURONS; k++) begin
            rd_data[k*OUT_BITS +: OUT_BITS] = lut_q[k][s1_addr_q[k*IN_BITS +: IN_BITS]];
        end
    end

    // rd_data is sampled on the S2 load edge, so a same-edge write still returns the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            s1_valid_q  <= bus.in_valid && in_ready;
            s1_addr_q   <= bus.in_data;
            out_valid_q <= s1_valid_q;
            out_data_q  <= rd_data;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.cfg_ready = run;
    assign bus.init_done = run;
endmodule

// File: tb/tb_lut_neuron_array.sv
// Scoreboard bench for lut_neuron_array: expected lookups queued at handshake,
// popped and compared when the array presents each output.
module tb_lut_neuron_array;
    localparam int N  = 4;
    localparam int IB = 8;
    localparam int OB = 2;
    localparam int NW = 2;
    localparam int DW = N * IB;
    localparam int OW = N * OB;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [OW-1:0] sb_q[$];
    logic [OB-1:0] model [N][2**IB];

    lut_neuron_array_if #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) bus ();

    lut_neuron_array #(.N_NEURONS(N), .IN_BITS(IB), .OUT_BITS(OB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [OW-1:0] model_out(input logic [DW-1:0] v);
        logic [OW-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) r[k*OB +: OB] = model[k][v[k*IB +: IB]];
        return r;
    endfunction

    task automatic clear_model();
        for (int k = 0; k < N; k++)
            for (int a = 0; a < 2**IB; a++) model[k][a] = '0;
    endtask

    // Output monitor: every accepted output must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got %h, none expected", bus.out_data);
            end else begin
                logic [OW-1:0] exp_v;
                exp_v = sb_q.pop_front();
                if (bus.out_data !== exp_v) begin
                    errors++;
                    $display("FAIL out_data: got %h expected %h", bus.out_data, exp_v);
                end
            end
        end
    end

    task automatic send_vec(input logic [DW-1:0] v);
        logic acc;
        int   n;
        bus.in_data  = v;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = bus.in_ready;
            if (acc) sb_q.push_back(model_out(v));
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL send_timeout: in_ready got 0 for %0d cycles, required 1", n);
        end
    endtask

    task automatic cfg_write(input logic [NW-1:0] n, input logic [IB-1:0] a, input logic [OB-1:0] d);
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = n;
        bus.cfg_addr   = a;
        bus.cfg_data   = d;
        @(negedge clk);
        checks++;
        if (bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_run: got %b required 1", bus.cfg_ready);
        end
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        model[n][a] = d;
    endtask

    // Releases reset and measures the length of the clear sweep.
    task automatic release_and_init(input bit init_write);
        int cnt;
        rst = 1'b0;
        cnt = 0;
        while (cnt < 1000) begin
            @(negedge clk);
            if (bus.init_done) break;
            if (init_write && cnt == 250) begin
                checks++;
                if (bus.cfg_ready !== 1'b0 || bus.in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL init_ready: cfg_ready %b in_ready %b, required 0 0",
                             bus.cfg_ready, bus.in_ready);
                end
                bus.cfg_we     = 1'b1;
                bus.cfg_neuron = 2'd2;
                bus.cfg_addr   = 8'h03;
                bus.cfg_data   = 2'b11;
            end
            if (init_write && cnt == 251) bus.cfg_we = 1'b0;
            cnt++;
        end
        checks++;
        if (cnt != 256) begin
            errors++;
            $display("FAIL init_length: got %0d cycles required 256", cnt);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_ready: in_ready %b cfg_ready %b, required 1 1",
                     bus.in_ready, bus.cfg_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.init_done !== 1'b0 ||
            bus.in_ready !== 1'b0 || bus.cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: out_valid %b out_data %h init_done %b in_ready %b cfg_ready %b, required all 0",
                     bus.out_valid, bus.out_data, bus.init_done, bus.in_ready, bus.cfg_ready);
        end
        @(posedge clk);
        #1;
        clear_model();
        release_and_init(1'b1);
    endtask

    task automatic test_cfg_during_init();
        logic [DW-1:0] v;
        v = '0;
        v[23:16] = 8'h03;
        send_vec(v);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_single();
        logic [DW-1:0] v;
        cfg_write(2'd1, 8'h41, 2'b10);
        v = '0;
        v[15:8] = 8'h41;
        send_vec(v);
        bus.in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: out_valid got %b required 0", bus.out_valid);
        end
        @(negedge clk);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 8'h08) begin
            errors++;
            $display("FAIL single_lookup: out_valid %b out_data %h, required 1 08",
                     bus.out_valid, bus.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] vecs[10];
        int run_len;
        int n;
        for (int i = 0; i < 10; i++) begin
            vecs[i] = '0;
            for (int k = 0; k < N; k++) begin
                vecs[i][k*IB +: IB] = 8'(i * 16 + k + 1);
                cfg_write(2'(k), 8'(i * 16 + k + 1), 2'($urandom_range(0, 3)));
            end
        end
        run_len = 0;
        fork
            begin
                for (int i = 0; i < 10; i++) send_vec(vecs[i]);
                bus.in_valid = 1'b0;
            end
            begin
                n = 0;
                while (n < 40) begin
                    @(negedge clk);
                    if (bus.out_valid) break;
                    n++;
                end
                while (bus.out_valid && run_len < 20) begin
                    run_len++;
                    @(negedge clk);
                end
            end
        join
        checks++;
        if (run_len != 10) begin
            errors++;
            $display("FAIL back_to_back_run: got %0d consecutive outputs required 10", run_len);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        logic [DW-1:0] va;
        logic [DW-1:0] vb;
        logic [DW-1:0] junk;
        va   = {8'h31, 8'h21, 8'h11, 8'h01};
        vb   = {8'h94, 8'h83, 8'h72, 8'h61};
        junk = {8'hC4, 8'hB3, 8'hA2, 8'h91};
        send_vec(va);
        send_vec(vb);
        bus.out_ready = 1'b0;
        bus.in_data   = junk;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_in_ready: cycle %0d got %b required 0", c, bus.in_ready);
            end
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL stall_hold: scoreboard empty, out_data %h", bus.out_data);
            end else if (bus.out_valid !== 1'b1 || bus.out_data !== sb_q[0]) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d out_valid %b out_data %h, required 1 %h",
                         c, bus.out_valid, bus.out_data, sb_q[0]);
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d outputs outstanding, required 0", sb_q.size());
        end
    endtask

    task automatic test_write_collision();
        logic [DW-1:0] v;
        cfg_write(2'd0, 8'h22, 2'b01);
        v = '0;
        v[7:0] = 8'h22;
        send_vec(v);
        bus.in_valid   = 1'b0;
        bus.cfg_we     = 1'b1;
        bus.cfg_neuron = 2'd0;
        bus.cfg_addr   = 8'h22;
        bus.cfg_data   = 2'b11;
        @(posedge clk);
        #1;
        bus.cfg_we = 1'b0;
        model[0][8'h22] = 2'b11;
        send_vec(v);
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset_inflight();
        logic [DW-1:0] v;
        send_vec({8'h01, 8'h02, 8'h41, 8'h22});
        send_vec({8'h11, 8'h12, 8'h13, 8'h14});
        bus.in_valid = 1'b0;
        rst = 1'b1;
        sb_q.delete();
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || bus.init_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_inflight: out_valid %b out_data %h init_done %b, required 0 00 0",
                     bus.out_valid, bus.out_data, bus.init_done);
        end
        repeat (2) @(posedge clk);
        #1;
        clear_model();
        release_and_init(1'b0);
        send_vec({8'h03, 8'h03, 8'h41, 8'h22});
        for (int i = 0; i < 4; i++) begin
            v = '0;
            for (int k = 0; k < N; k++) v[k*IB +: IB] = 8'(i * 16 + k + 1);
            send_vec(v);
        end
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.in_data    = '0;
        bus.in_valid   = 1'b0;
        bus.out_ready  = 1'b1;
        bus.cfg_we     = 1'b0;
        bus.cfg_neuron = '0;
        bus.cfg_addr   = '0;
        bus.cfg_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        test_cfg_during_init();
        test_single();
        test_back_to_back();
        test_stall();
        test_write_collision();
        test_reset_inflight();
        begin
            int n;
            n = 0;
            while (sb_q.size() != 0 && n < 50) begin
                @(posedge clk);
                n++;
            end
            #1;
            checks++;
            if (sb_q.size() != 0) begin
                errors++;
                $display("FAIL final_drain: %0d outputs outstanding, required 0", sb_q.size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
